// File: rtl/stackcalc_feeder.sv
// Command FIFO and slow-clock/reset sequencer in front of the stack calculator.
// Optional FEEDER_ISSUECNT_EN adds a 16-bit count of issued commands.
module stackcalc_feeder #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned HALF_PERIOD = 2
) (
  input  logic                     globclk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_mode,
  input  logic [3:0]               cmd_data,
  input  logic                     calc_rst_req,
  output logic [7:0]               calc_in,
  input  logic [7:0]               calc_out,
  output logic                     res_valid,
  output logic [7:0]               res_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy
`ifdef FEEDER_ISSUECNT_EN
  ,
  output logic [15:0]              issue_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(HALF_PERIOD + 1);
  localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HIGH, S_HOLD, S_CAPTURE, S_RST_A, S_RST_B, S_RST_C
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q;
  logic [5:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic            rst_pending_q;
  logic [7:0]      calc_in_q;
  logic            res_valid_q;
  logic [7:0]      res_data_q;
  logic            calc_rst_d, calc_clk_d;
  logic            timer_last, push, pop, enter_rst;

  assign timer_last = (timer_q == TIMER_LAST);
  assign cmd_ready  = (count_q != FULL_LEVEL);
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state_q == S_IDLE) && !rst_pending_q && (count_q != '0);
  assign enter_rst  = (state_q == S_IDLE) && (state_d == S_RST_A);

  // State register; the phase timer restarts on every state change
  always_ff @(posedge globclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= (state_d != state_q) ? '0 : timer_q + TW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (rst_pending_q)        state_d = S_RST_A;
                 else if (count_q != '0)   state_d = S_SETUP;
      S_SETUP:   if (timer_last) state_d = S_HIGH;
      S_HIGH:    if (timer_last) state_d = S_HOLD;
      S_HOLD:    if (timer_last) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_IDLE;
      S_RST_A:   if (timer_last) state_d = S_RST_B;
      S_RST_B:   if (timer_last) state_d = S_RST_C;
      S_RST_C:   if (timer_last) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Calculator clk/rst are decoded from the next state so the registered bus lines up with it
  always_comb begin
    calc_rst_d = 1'b0;
    calc_clk_d = 1'b0;
    case (state_d)
      S_HIGH:           calc_clk_d = 1'b1;
      S_RST_A, S_RST_C: calc_rst_d = 1'b1;
      S_RST_B: begin
        calc_rst_d = 1'b1;
        calc_clk_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge globclk) begin
    if (push) mem[wr_ptr_q] <= {cmd_mode, cmd_data};
  end

  always_ff @(posedge globclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: ;
      endcase
    end
  end

  // A request landing on the RST_A entry cycle wins, so it is never lost
  always_ff @(posedge globclk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pending_q <= 1'b1;
      calc_in_q     <= 8'h02;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
    end else begin
      rst_pending_q  <= calc_rst_req || (rst_pending_q && !enter_rst);
      if (pop) calc_in_q[7:2] <= mem[rd_ptr_q];
      calc_in_q[1:0] <= {calc_rst_d, calc_clk_d};
      res_valid_q    <= (state_q == S_CAPTURE);
      if (state_q == S_CAPTURE) res_data_q <= calc_out;
    end
  end

`ifdef FEEDER_ISSUECNT_EN
  logic [15:0] issue_cnt_q;

  always_ff @(posedge globclk or negedge rst_n) begin
    if (!rst_n)   issue_cnt_q <= '0;
    else if (pop) issue_cnt_q <= issue_cnt_q + 16'd1;
  end

  assign issue_count = issue_cnt_q;
`endif

  assign calc_in   = calc_in_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign level     = count_q;
  assign busy      = (state_q != S_IDLE) || rst_pending_q;

endmodule
